sub_bytes_serial: RTL

Parametrised, lane-sliced AES SubBytes / InvSubBytes engine with valid/ready handshakes on input and output. It substitutes a 128-bit AES state through `LANES` S-box lanes over `16/LANES` cycles. This trades area against latency, so the same block serves both the compact iterative core and the unrolled core. It sits in the round datapath between AddRoundKey and ShiftRows, and is also used for the key-expansion SubWord when `LANES=4`.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/inv_s_box.sv | 11 +
 rtl/s_box.sv | 11 +
 rtl/sbox_lane.sv | 32 +++
 rtl/sub_bytes_serial.sv | 98 +++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, state-byte indexing and GF(2^8) helpers used across the round datapath.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sbs_state_e;

  // Byte 0 is the most significant byte of the state.
  function automatic int unsigned aes_byte_lsb(input int unsigned idx);
    return AES_STATE_W - 8 - 8 * idx;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/inv_s_box.sv
// Inverse AES S-box: inverse affine map followed by inversion in GF(2^8).
module inv_s_box
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = gf_inv(aff_inv(i_byte));

endmodule

// File: rtl/s_box.sv
// Forward AES S-box: inversion in GF(2^8) followed by the affine map.
module s_box
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = aff_fwd(gf_inv(i_byte));

endmodule

// File: rtl/sbox_lane.sv
// One substitution lane: forward S-box, plus an inverse S-box and output mux when INV_EN is set.
module sbox_lane #(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] i_data,
  input  logic       i_inv,
  output logic [7:0] o_data
);

  logic [7:0] w_fwd;

  s_box u_fwd (
    .i_byte(i_data),
    .o_byte(w_fwd)
  );

  if (INV_EN) begin : g_inv
    logic [7:0] w_inv;

    inv_s_box u_inv (
      .i_byte(i_data),
      .o_byte(w_inv)
    );

    assign o_data = i_inv ? w_inv : w_fwd;
  end else begin : g_fwd_only
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
    assign o_data       = w_fwd;
  end

endmodule

// File: rtl/sub_bytes_serial.sv
// Lane-sliced SubBytes/InvSubBytes engine: substitutes LANES bytes per cycle over 16/LANES cycles.
module sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter bit          INV_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned N    = AES_NBYTES / LANES;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  sbs_state_e             r_fsm, w_fsm_nxt;
  logic [AES_STATE_W-1:0] r_state, w_state_nxt;
  logic                   r_mode, w_mode_nxt;
  logic [CntW-1:0]        r_cnt, w_cnt_nxt;
  logic [7:0]             w_lane_in  [LANES];
  logic [7:0]             w_lane_out [LANES];

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane_in[l] = r_state[aes_byte_lsb(32'(r_cnt) * LANES + l) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_lane #(
      .INV_EN(INV_EN)
    ) u_lane (
      .i_data(w_lane_in[g]),
      .i_inv (r_mode),
      .o_data(w_lane_out[g])
    );
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    unique case (r_fsm)
      StIdle: begin
        if (in_valid) begin
          w_state_nxt = in_data;
          w_mode_nxt  = in_inv & INV_EN;
          w_cnt_nxt   = '0;
          w_fsm_nxt   = StRun;
        end
      end
      StRun: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          w_state_nxt[aes_byte_lsb(32'(r_cnt) * LANES + l) +: 8] = w_lane_out[l];
        end
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == CntW'(N - 1)) w_fsm_nxt = StDone;
      end
      StDone: begin
        if (out_ready) w_fsm_nxt = StIdle;
      end
      default: w_fsm_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs are gated by rst so they read as idle/zero even before the first reset edge.
  assign in_ready  = (r_fsm == StIdle) & ~rst;
  assign out_valid = (r_fsm == StDone) & ~rst;
  assign busy      = ((r_fsm == StRun) | (r_fsm == StDone)) & ~rst;
  assign out_data  = rst ? '0 : r_state;

endmodule
